// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter: merges in-order ALU results with out-of-band load returns.
// Losing loads wait in a small FIFO. A starvation limit forces drains, and younger ALU writes kill stale queued loads.
module regfile_wb_arbiter #(
    parameter int DBITS        = 32,
    parameter int ABITS        = 4,
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ALU_WE,
    input  logic [ABITS-1:0] ALU_WADDR,
    input  logic [DBITS-1:0] ALU_DIN,
    output logic             ALU_STALL,
    input  logic             LD_VALID,
    input  logic [ABITS-1:0] LD_WADDR,
    input  logic [DBITS-1:0] LD_DIN,
    output logic             LD_READY,
    output logic             EMPTY,
    output logic             WE,
    output logic [ABITS-1:0] WADDR,
    output logic [DBITS-1:0] DIN
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_FORCED,
        SEL_ALU,
        SEL_POP,
        SEL_DIRECT
    } sel_e;

    logic [ABITS-1:0]  q_addr [QDEPTH];
    logic [DBITS-1:0]  q_data [QDEPTH];
    logic [QDEPTH-1:0] q_kill, kill_next;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve;

    sel_e sel;
    logic pop, push, alu_issue, direct;

    assign EMPTY     = (count == '0);
    assign LD_READY  = (count < CW'(QDEPTH));
    assign ALU_STALL = (starve == SW'(STARVE_LIMIT));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = SEL_IDLE;
        if (ALU_STALL && !EMPTY)  sel = SEL_FORCED;
        else if (ALU_WE)          sel = SEL_ALU;
        else if (!EMPTY)          sel = SEL_POP;
        else if (LD_VALID)        sel = SEL_DIRECT;

        pop       = (sel == SEL_FORCED) || (sel == SEL_POP);
        alu_issue = (sel == SEL_ALU);
        direct    = (sel == SEL_DIRECT);
        push      = LD_VALID && LD_READY && !direct;
    end

    // An issued ALU write kills every live queued load aimed at the same register; the
    // load being pushed this cycle is younger and lands with a clear kill bit.
    always_comb begin
        logic [PW-1:0] offset;
        kill_next = q_kill;
        for (int i = 0; i < QDEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if (alu_issue && ({1'b0, offset} < count) && (q_addr[i] == ALU_WADDR))
                kill_next[i] = 1'b1;
        end
        if (push)
            kill_next[wr_ptr] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            q_kill <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (EMPTY || pop)  starve <= '0;
            else if (!ALU_STALL) starve <= starve + 1'b1;
            q_kill <= kill_next;
        end
    end

    // NOTE: the payload storage is not reset. Reset clears count and kill bits, and entries are written before they are read.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_addr[wr_ptr] <= LD_WADDR;
            q_data[wr_ptr] <= LD_DIN;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            WE    <= 1'b0;
            WADDR <= '0;
            DIN   <= '0;
        end else begin
            WE <= 1'b0;
            case (sel)
                SEL_ALU: begin
                    WE    <= 1'b1;
                    WADDR <= ALU_WADDR;
                    DIN   <= ALU_DIN;
                end
                SEL_FORCED, SEL_POP: begin
                    if (!q_kill[rd_ptr]) begin
                        WE    <= 1'b1;
                        WADDR <= q_addr[rd_ptr];
                        DIN   <= q_data[rd_ptr];
                    end
                end
                SEL_DIRECT: begin
                    WE    <= 1'b1;
                    WADDR <= LD_WADDR;
                    DIN   <= LD_DIN;
                end
                default: ;
            endcase
        end
    end

endmodule
